echo_pipeline_sequencer: RTL and testbench

- Per-sample controller for the lag16 echo-cancellation chain: sig16b-to-double conversion, lag/align, parameter approximation, echo cancellation, double-to-sig16b.
- Replaces the fixed-delay enable timing with a ready-driven FSM.
- Runs in TRAIN mode (adaptation) for MAX_ITERATION samples, then switches permanently to CANCEL mode.
- Selects the 64-bit double routed to the output converter.

---
 rtl/echo_pipeline_sequencer_pkg.sv | 37 +++
 rtl/echo_pipeline_sequencer_handshake.sv | 82 ++++++++
 rtl/echo_pipeline_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_echo_pipeline_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/echo_pipeline_sequencer_pkg.sv
// Shared types and constants for the echo pipeline sequencer.
// Used by both the top FSM and the stage handshake sub-module.
package echo_pipeline_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CONV = 3'd1,
    ST_LAG  = 3'd2,
    ST_CORE = 3'd3,
    ST_OUT  = 3'd4
  } seq_state_e;

  typedef enum logic [1:0] {
    STG_CONV   = 2'd0,
    STG_LAG    = 2'd1,
    STG_APPROX = 2'd2,
    STG_CANCEL = 2'd3
  } stage_e;

  typedef enum logic [1:0] {
    HS_IDLE  = 2'd0,
    HS_PULSE = 2'd1,
    HS_WAIT  = 2'd2
  } hs_phase_e;

  localparam logic [63:0] DOUBLE_ZERO       = 64'h0;
  localparam int          DEF_PULSE_CYCLES  = 2;
  localparam int          DEF_TIMEOUT       = 1024;
  localparam int          DEF_MAX_ITERATION = 512;
  localparam int          ITER_W            = 11;
  localparam logic [ITER_W-1:0] ITER_MAX    = '1;

  function automatic logic [ITER_W-1:0] sat_inc_iter(input logic [ITER_W-1:0] v);
    return (v == ITER_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/echo_pipeline_sequencer_handshake.sv
// Shared stage handshake: fixed-width enable pulse, then a bounded wait for the
// selected stage's ready. One instance serves all four stages via start_stage.
module echo_pipeline_sequencer_handshake
  import echo_pipeline_sequencer_pkg::*;
#(
  parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic       clk_operation,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] start_stage,
  input  logic [3:0] ready,
  output logic [3:0] enable,
  output logic       done,
  output logic       timeout
);

  localparam logic [3:0]  PULSE_W   = 4'(PULSE_CYCLES);
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  hs_phase_e   phase_q, phase_d;
  logic [3:0]  pulse_cnt_q, pulse_cnt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]  stage_q, stage_d;

  always_ff @(posedge clk_operation or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= HS_IDLE;
      pulse_cnt_q <= '0;
      wait_cnt_q  <= '0;
      stage_q     <= '0;
    end else begin
      phase_q     <= phase_d;
      pulse_cnt_q <= pulse_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      stage_q     <= stage_d;
    end
  end

  always_comb begin
    phase_d     = phase_q;
    pulse_cnt_d = pulse_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    stage_d     = stage_q;
    done        = 1'b0;
    timeout     = 1'b0;
    enable      = '0;

    case (phase_q)
      HS_PULSE: begin
        enable[stage_q] = 1'b1;
        if (pulse_cnt_q == 4'd1) begin
          phase_d    = HS_WAIT;
          wait_cnt_d = TIMEOUT_W;
        end else begin
          pulse_cnt_d = pulse_cnt_q - 4'd1;
        end
      end
      HS_WAIT: begin
        // Ready on the last allowed wait cycle still wins over the timeout.
        if (ready[stage_q]) begin
          done    = 1'b1;
          phase_d = HS_IDLE;
        end else if (wait_cnt_q == 16'd1) begin
          timeout = 1'b1;
          phase_d = HS_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q - 16'd1;
        end
      end
      default: ;
    endcase

    if (start) begin
      phase_d     = HS_PULSE;
      pulse_cnt_d = PULSE_W;
      stage_d     = start_stage;
    end
  end

endmodule

// File: rtl/echo_pipeline_sequencer.sv
// Per-sample sequencer for the lag16 echo-cancellation chain (TRAIN then CANCEL).
// Optional SEQ_STATUS_COUNTERS_EN adds saturating overrun/timeout event counters.
//
// state   | meaning
// IDLE    | waiting for sampling_cycle_counter == 0
// CONV    | sig16b-to-double stage pulsed / awaiting ready_conv
// LAG     | lag generator pulsed / awaiting ready_lag
// CORE    | approximation (TRAIN) or cancellation (CANCEL) in flight
// OUT     | one cycle: latch double_out, update iteration and mode
module echo_pipeline_sequencer
  import echo_pipeline_sequencer_pkg::*;
#(
  parameter int PULSE_CYCLES  = DEF_PULSE_CYCLES,
  parameter int TIMEOUT       = DEF_TIMEOUT,
  parameter int MAX_ITERATION = DEF_MAX_ITERATION
) (
  input  logic        clk_operation,
  input  logic        rst_n,
  input  logic [12:0] sampling_cycle_counter,
  input  logic        ready_conv,
  input  logic        ready_lag,
  input  logic        ready_approx,
  input  logic        ready_cancel,
  input  logic [63:0] e,
  input  logic [63:0] signal_without_echo,
  output logic        enable_conv,
  output logic        enable_lag,
  output logic        enable_approx,
  output logic        enable_cancel,
  output logic        enable_sampling_lag,
  output logic        enable_sampling_approx,
  output logic        enable_sampling_cancel,
  output logic        enable_out,
  output logic [63:0] double_out,
  output logic        train_mode,
  output logic [10:0] iteration,
  output logic        overrun,
`ifdef SEQ_STATUS_COUNTERS_EN
  output logic [15:0] overrun_count,
  output logic [15:0] timeout_count,
`endif
  output logic        timeout_err
);

  localparam logic [ITER_W-1:0] MAX_ITER_W = ITER_W'(MAX_ITERATION);

  seq_state_e        state_q, state_d;
  logic [63:0]       double_out_q, double_out_d;
  logic              enable_out_q, enable_out_d;
  logic [ITER_W-1:0] iteration_q, iteration_d;
  logic              train_mode_q, train_mode_d;
  logic              samp_core_q, samp_core_d;
  logic              overrun_q, overrun_d;
  logic              timeout_err_q, timeout_err_d;

  logic       sample_start, overrun_evt, timeout_evt;
  logic       hs_start, hs_done, hs_timeout;
  stage_e     hs_stage, core_stage;
  logic [3:0] hs_enable;

  echo_pipeline_sequencer_handshake #(
    .PULSE_CYCLES(PULSE_CYCLES),
    .TIMEOUT     (TIMEOUT)
  ) u_handshake (
    .clk_operation(clk_operation),
    .rst_n        (rst_n),
    .start        (hs_start),
    .start_stage  (hs_stage),
    .ready        ({ready_cancel, ready_approx, ready_lag, ready_conv}),
    .enable       (hs_enable),
    .done         (hs_done),
    .timeout      (hs_timeout)
  );

  always_ff @(posedge clk_operation or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      double_out_q  <= DOUBLE_ZERO;
      enable_out_q  <= 1'b0;
      iteration_q   <= '0;
      train_mode_q  <= 1'b1;
      samp_core_q   <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      double_out_q  <= double_out_d;
      enable_out_q  <= enable_out_d;
      iteration_q   <= iteration_d;
      train_mode_q  <= train_mode_d;
      samp_core_q   <= samp_core_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    double_out_d = double_out_q;
    enable_out_d = enable_out_q;
    iteration_d  = iteration_q;
    train_mode_d = train_mode_q;
    samp_core_d  = samp_core_q;
    hs_start     = 1'b0;
    hs_stage     = STG_CONV;
    timeout_evt  = 1'b0;
    sample_start = (sampling_cycle_counter == 13'd0);
    overrun_evt  = sample_start && (state_q != ST_IDLE);
    core_stage   = train_mode_q ? STG_APPROX : STG_CANCEL;

    case (state_q)
      ST_IDLE: if (sample_start) begin
        state_d  = ST_CONV;
        hs_start = 1'b1;
        hs_stage = STG_CONV;
      end
      ST_CONV: if (hs_done) begin
        state_d  = ST_LAG;
        hs_start = 1'b1;
        hs_stage = STG_LAG;
      end
      ST_LAG: if (hs_done) begin
        state_d     = ST_CORE;
        samp_core_d = 1'b1;
        hs_start    = 1'b1;
        hs_stage    = core_stage;
      end
      ST_CORE: if (hs_done) state_d = ST_OUT;
      ST_OUT: begin
        double_out_d = train_mode_q ? e : signal_without_echo;
        enable_out_d = 1'b1;
        // Mode flips here only, so the next sample is the first in CANCEL.
        if (train_mode_q) begin
          iteration_d = sat_inc_iter(iteration_q);
          if (iteration_d >= MAX_ITER_W) train_mode_d = 1'b0;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (hs_timeout) begin
      timeout_evt = 1'b1;
      state_d     = ST_IDLE;
    end

    overrun_d     = overrun_q | overrun_evt;
    timeout_err_d = timeout_err_q | timeout_evt;
  end

`ifdef SEQ_STATUS_COUNTERS_EN
  logic [15:0] overrun_count_q, overrun_count_d;
  logic [15:0] timeout_count_q, timeout_count_d;

  always_ff @(posedge clk_operation or negedge rst_n) begin
    if (!rst_n) begin
      overrun_count_q <= '0;
      timeout_count_q <= '0;
    end else begin
      overrun_count_q <= overrun_count_d;
      timeout_count_q <= timeout_count_d;
    end
  end

  always_comb begin
    overrun_count_d = overrun_count_q;
    timeout_count_d = timeout_count_q;
    if (overrun_evt && overrun_count_q != 16'hFFFF) overrun_count_d = overrun_count_q + 16'd1;
    if (timeout_evt && timeout_count_q != 16'hFFFF) timeout_count_d = timeout_count_q + 16'd1;
  end

  assign overrun_count = overrun_count_q;
  assign timeout_count = timeout_count_q;
`endif

  assign enable_conv            = hs_enable[STG_CONV];
  assign enable_lag             = hs_enable[STG_LAG];
  assign enable_approx          = hs_enable[STG_APPROX];
  assign enable_cancel          = hs_enable[STG_CANCEL];
  assign enable_sampling_lag    = 1'b1;
  assign enable_sampling_approx = samp_core_q;
  assign enable_sampling_cancel = samp_core_q;
  assign enable_out             = enable_out_q;
  assign double_out             = double_out_q;
  assign train_mode             = train_mode_q;
  assign iteration              = iteration_q;
  assign overrun                = overrun_q;
  assign timeout_err            = timeout_err_q;

endmodule

// File: tb/tb_echo_pipeline_sequencer.sv
// Directed bench for echo_pipeline_sequencer (PULSE_CYCLES=2, TIMEOUT=16, MAX_ITERATION=4).
module tb_echo_pipeline_sequencer;

  logic        clk_operation = 1'b0;
  logic        rst_n;
  logic [12:0] sampling_cycle_counter;
  logic        ready_conv, ready_lag, ready_approx, ready_cancel;
  logic [63:0] e, signal_without_echo;
  logic        enable_conv, enable_lag, enable_approx, enable_cancel;
  logic        enable_sampling_lag, enable_sampling_approx, enable_sampling_cancel;
  logic        enable_out;
  logic [63:0] double_out;
  logic        train_mode;
  logic [10:0] iteration;
  logic        overrun, timeout_err;
`ifdef SEQ_STATUS_COUNTERS_EN
  logic [15:0] overrun_count, timeout_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_operation = ~clk_operation;

  echo_pipeline_sequencer #(
    .PULSE_CYCLES (2),
    .TIMEOUT      (16),
    .MAX_ITERATION(4)
  ) dut (
    .clk_operation         (clk_operation),
    .rst_n                 (rst_n),
    .sampling_cycle_counter(sampling_cycle_counter),
    .ready_conv            (ready_conv),
    .ready_lag             (ready_lag),
    .ready_approx          (ready_approx),
    .ready_cancel          (ready_cancel),
    .e                     (e),
    .signal_without_echo   (signal_without_echo),
    .enable_conv           (enable_conv),
    .enable_lag            (enable_lag),
    .enable_approx         (enable_approx),
    .enable_cancel         (enable_cancel),
    .enable_sampling_lag   (enable_sampling_lag),
    .enable_sampling_approx(enable_sampling_approx),
    .enable_sampling_cancel(enable_sampling_cancel),
    .enable_out            (enable_out),
    .double_out            (double_out),
    .train_mode            (train_mode),
    .iteration             (iteration),
    .overrun               (overrun),
`ifdef SEQ_STATUS_COUNTERS_EN
    .overrun_count         (overrun_count),
    .timeout_count         (timeout_count),
`endif
    .timeout_err           (timeout_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] en_vec();
    return {enable_cancel, enable_approx, enable_lag, enable_conv};
  endfunction

  function automatic logic en_bit(input int which);
    logic [3:0] v;
    v = en_vec();
    return v[which];
  endfunction

  task automatic set_ready(input int which, input logic v);
    case (which)
      0: ready_conv   = v;
      1: ready_lag    = v;
      2: ready_approx = v;
      default: ready_cancel = v;
    endcase
  endtask

  task automatic start_sample();
    sampling_cycle_counter = 13'd0;
    @(negedge clk_operation);
    sampling_cycle_counter = 13'd5;
  endtask

  // Measure one stage pulse; delay >= 0 returns ready on wait cycle delay+1.
  task automatic run_stage(input int which, input int delay, input string tag);
    int guard = 0;
    int w = 0;
    logic [3:0] exp_v;
    exp_v = 4'b0001 << which;
    while (!en_bit(which) && guard < 50) begin
      @(negedge clk_operation);
      guard++;
    end
    check({tag, " launch"}, 64'(guard < 50), 64'd1);
    while (en_bit(which) && w < 20) begin
      check({tag, " onehot"}, 64'(en_vec()), 64'(exp_v));
      @(negedge clk_operation);
      w++;
    end
    check({tag, " width"}, 64'(w), 64'd2);
    if (delay >= 0) begin
      repeat (delay) @(negedge clk_operation);
      set_ready(which, 1'b1);
      @(negedge clk_operation);
      set_ready(which, 1'b0);
    end
  endtask

  task automatic run_sample(input logic [63:0] ev, input logic [63:0] sv, input int core,
                            input int lag_delay, input string tag);
    e = ev;
    signal_without_echo = sv;
    start_sample();
    run_stage(0, 3, {tag, " conv"});
    run_stage(1, lag_delay, {tag, " lag"});
    run_stage(core, 3, {tag, " core"});
    @(negedge clk_operation);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " enables"}, 64'(en_vec()), 64'd0);
    check({tag, " enable_out"}, 64'(enable_out), 64'd0);
    check({tag, " double_out"}, double_out, 64'd0);
    check({tag, " iteration"}, 64'(iteration), 64'd0);
    check({tag, " train_mode"}, 64'(train_mode), 64'd1);
    check({tag, " samp_lag"}, 64'(enable_sampling_lag), 64'd1);
    check({tag, " samp_approx"}, 64'(enable_sampling_approx), 64'd0);
    check({tag, " samp_cancel"}, 64'(enable_sampling_cancel), 64'd0);
    check({tag, " overrun"}, 64'(overrun), 64'd0);
    check({tag, " timeout_err"}, 64'(timeout_err), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    logic [63:0] ev, sv;

    rst_n = 1'b0;
    sampling_cycle_counter = 13'd5;
    {ready_conv, ready_lag, ready_approx, ready_cancel} = 4'b0;
    e = 64'd0;
    signal_without_echo = 64'd0;
    repeat (3) @(negedge clk_operation);
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk_operation);
    check("idle no launch", 64'(en_vec()), 64'd0);

    // One complete TRAIN sample, then reset in the middle of the next one's CORE pulse.
    run_sample(64'h3FF0_0000_0000_00A1, 64'h4000_0000_0000_00B1, 2, 3, "pre");
    check("pre double_out", double_out, 64'h3FF0_0000_0000_00A1);
    check("pre iteration", 64'(iteration), 64'd1);
    check("pre samp_approx", 64'(enable_sampling_approx), 64'd1);
    check("pre samp_cancel", 64'(enable_sampling_cancel), 64'd1);
    e = 64'h3FF0_0000_0000_00A2;
    start_sample();
    run_stage(0, 3, "mid conv");
    run_stage(1, 3, "mid lag");
    check("mid approx high", 64'(enable_approx), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_values("async reset");
    @(negedge clk_operation);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_operation);
    check("post reset idle", 64'(en_vec()), 64'd0);
    check("post reset double_out", double_out, 64'd0);

    // Four TRAIN samples; mode drops after the fourth.
    for (int i = 1; i <= 4; i++) begin
      ev = 64'h3FF0_0000_0000_0000 + 64'(i);
      sv = 64'h4010_0000_0000_0000 + 64'(i);
      run_sample(ev, sv, 2, 3, "train");
      check("train double_out", double_out, ev);
      check("train iteration", 64'(iteration), 64'(i));
      check("train enable_out", 64'(enable_out), 64'd1);
      check("train mode", 64'(train_mode), (i < 4) ? 64'd1 : 64'd0);
    end

    run_sample(64'h3FF0_0000_0000_0005, 64'h4010_0000_0000_0005, 3, 3, "cancel");
    check("cancel double_out", double_out, 64'h4010_0000_0000_0005);
    check("cancel iteration", 64'(iteration), 64'd4);
    check("cancel mode", 64'(train_mode), 64'd0);

    // Stale ready: held-high ready_conv is only taken after the pulse ends.
    e = 64'h3FF0_0000_0000_0006;
    signal_without_echo = 64'h4010_0000_0000_0006;
    ready_conv = 1'b1;
    start_sample();
    run_stage(0, -1, "stale conv");
    check("stale lag waits", 64'(enable_lag), 64'd0);
    @(negedge clk_operation);
    check("stale lag starts", 64'(enable_lag), 64'd1);
    ready_conv = 1'b0;
    run_stage(1, 3, "stale lag");
    run_stage(3, 3, "stale core");
    @(negedge clk_operation);
    check("stale double_out", double_out, 64'h4010_0000_0000_0006);

    // Ready on the final (16th) wait cycle is a success, not a timeout.
    run_sample(64'h3FF0_0000_0000_0007, 64'h4010_0000_0000_0007, 3, 15, "edge");
    check("edge timeout_err", 64'(timeout_err), 64'd0);
    check("edge double_out", double_out, 64'h4010_0000_0000_0007);

    // Timeout in LAG.
    e = 64'h3FF0_0000_0000_0008;
    signal_without_echo = 64'h4010_0000_0000_0008;
    start_sample();
    run_stage(0, 3, "to conv");
    run_stage(1, -1, "to lag");
    cnt = 0;
    while (!timeout_err && cnt < 40) begin
      check("to no early flag", 64'(timeout_err), 64'd0);
      @(negedge clk_operation);
      cnt++;
    end
    check("to latency", 64'(cnt), 64'd16);
    check("to flag", 64'(timeout_err), 64'd1);
    check("to idle", 64'(en_vec()), 64'd0);
    check("to iteration", 64'(iteration), 64'd4);
    check("to double_out", double_out, 64'h4010_0000_0000_0007);
    repeat (3) @(negedge clk_operation);
    check("to no cancel", 64'(en_vec()), 64'd0);
    run_sample(64'h3FF0_0000_0000_0009, 64'h4010_0000_0000_0009, 3, 3, "after to");
    check("after to double_out", double_out, 64'h4010_0000_0000_0009);
    check("after to overrun", 64'(overrun), 64'd0);

    // Overrun: new sample start while CORE is still waiting.
    e = 64'h3FF0_0000_0000_000A;
    signal_without_echo = 64'h4010_0000_0000_000A;
    start_sample();
    run_stage(0, 3, "ov conv");
    run_stage(1, 3, "ov lag");
    run_stage(3, -1, "ov core");
    repeat (4) @(negedge clk_operation);
    sampling_cycle_counter = 13'd0;
    @(negedge clk_operation);
    sampling_cycle_counter = 13'd5;
    check("ov flag", 64'(overrun), 64'd1);
    check("ov no conv", 64'(en_vec()), 64'd0);
    repeat (3) @(negedge clk_operation);
    check("ov still no conv", 64'(en_vec()), 64'd0);
    ready_cancel = 1'b1;
    @(negedge clk_operation);
    ready_cancel = 1'b0;
    @(negedge clk_operation);
    check("ov double_out", double_out, 64'h4010_0000_0000_000A);
    check("ov flag sticky", 64'(overrun), 64'd1);

`ifdef SEQ_STATUS_COUNTERS_EN
    rst_n = 1'b0;
    @(negedge clk_operation);
    rst_n = 1'b1;
    @(negedge clk_operation);
    for (int k = 0; k < 3; k++) begin
      start_sample();
      run_stage(0, -1, "cnt conv");
      repeat (20) @(negedge clk_operation);
    end
    check("timeout_count", 64'(timeout_count), 64'd3);
    check("overrun_count", 64'(overrun_count), 64'd0);
    check("cnt timeout_err", 64'(timeout_err), 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
